// File: rtl/aes_pkg.sv
// Shared types, FIPS-197 substitution tables and lane slicing for the S-box engine.
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Bit offset of byte lane 'lane' within a packed multi-lane word.
    function automatic int unsigned lane_lsb(input int unsigned lane);
        return lane * 8;
    endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// Single-byte forward/inverse S-box with bypass; purely combinational.
module aes_sbox_lane
    import aes_pkg::*;
(
    input  byte_t byte_i,
    input  logic  inv_i,
    input  logic  bypass_i,
    output byte_t byte_o
);

    // Select bypass, forward or inverse table lookup.
    always_comb begin
        byte_o = byte_i;
        if (!bypass_i) begin
            byte_o = inv_i ? SBOX_INV[byte_i] : SBOX_FWD[byte_i];
        end
    end

endmodule

// File: rtl/aes_sbox_array.sv
// Multi-lane pipelined AES S-box engine with elastic valid/ready stages and
// a saturating accepted-beat counter. Lookup happens ahead of stage 0.
module aes_sbox_array
    import aes_pkg::*;
#(
    parameter int unsigned NLANES = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NLANES-1:0]   in_data,
    input  logic                  in_inv,
    input  logic [NLANES-1:0]     in_bypass,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NLANES-1:0]   out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic [CNT_W-1:0]      beat_cnt,
    input  logic                  clr_cnt
);

    logic [8*NLANES-1:0] sub_data;
    logic [STAGES-1:0]   v_q, v_d, src_v, load;
    logic [8*NLANES-1:0] data_q   [STAGES];
    logic [8*NLANES-1:0] src_data [STAGES];
    logic [TAG_W-1:0]    tag_q    [STAGES];
    logic [TAG_W-1:0]    src_tag  [STAGES];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                xfer_in;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        aes_sbox_lane u_lane (
            .byte_i   (in_data[lane_lsb(i) +: 8]),
            .inv_i    (in_inv),
            .bypass_i (in_bypass[i]),
            .byte_o   (sub_data[lane_lsb(i) +: 8])
        );
    end

    // Stage inputs: stage 0 takes the looked-up beat, later stages retime the previous one.
    always_comb begin
        src_v       = '0;
        src_v[0]    = in_valid;
        src_data[0] = sub_data;
        src_tag[0]  = in_tag;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_v[k]    = v_q[k-1];
            src_data[k] = data_q[k-1];
            src_tag[k]  = tag_q[k-1];
        end
    end

    // Ready chain walked from the output back: a stage loads when empty or draining.
    always_comb begin
        logic        chain;
        int unsigned k;
        chain = out_ready;
        load  = '0;
        v_d   = v_q;
        for (int unsigned j = 0; j < STAGES; j++) begin
            k       = STAGES - 1 - j;
            chain   = ~v_q[k] | chain;
            load[k] = chain;
        end
        for (int unsigned m = 0; m < STAGES; m++) begin
            if (load[m]) begin
                v_d[m] = src_v[m];
            end
        end
    end

    // Stage registers; payload only captured when a valid beat actually moves in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (load[k] && src_v[k]) begin
                    data_q[k] <= src_data[k];
                    tag_q[k]  <= src_tag[k];
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign xfer_in   = in_valid & load[0];
    assign out_valid = v_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign beat_cnt  = cnt_q;

    // Saturating beat count; a clear coinciding with a transfer counts that transfer.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = xfer_in ? CNT_W'(1) : '0;
        end else if (xfer_in && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Beat counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_aes_sbox_array.sv
// Directed self-checking bench for aes_sbox_array (4 lanes, 2 stages, 4-bit counter).
module tb_aes_sbox_array;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_inv;
    logic [3:0]  in_bypass;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic [3:0]  beat_cnt;
    logic        clr_cnt;

    int n_checks;
    int n_fail;

    logic [31:0] bp_d   [5];
    logic        bp_inv [5];
    logic [31:0] bp_exp [5];

    aes_sbox_array #(
        .NLANES (4),
        .STAGES (2),
        .TAG_W  (4),
        .CNT_W  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .in_bypass (in_bypass),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .beat_cnt  (beat_cnt),
        .clr_cnt   (clr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated beat with out_ready high: result visible exactly two cycles after transfer.
    task automatic single_beat(input string name, input logic [31:0] d, input logic inv,
                               input logic [3:0] byp, input logic [3:0] tag, input logic [31:0] exp_d);
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = d; in_inv = inv; in_bypass = byp; in_tag = tag;
        @(negedge clk);
        check({name, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = ~d; in_inv = ~inv; in_bypass = ~byp; in_tag = ~tag;
        @(negedge clk);
        check({name, "_early"}, out_valid, 0);
        @(negedge clk);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"}, out_data, exp_d);
        check({name, "_tag"}, out_tag, tag);
        @(negedge clk);
        check({name, "_oneshot"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic r;
        int   got;
        logic acc;

        n_checks = 0; n_fail = 0;
        clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0;
        in_bypass = '0; in_tag = '0; out_ready = 1'b1; clr_cnt = 1'b0;

        bp_d[0] = 32'h0010_2030; bp_inv[0] = 1'b0; bp_exp[0] = 32'h63CA_B704;
        bp_d[1] = 32'h4050_6070; bp_inv[1] = 1'b0; bp_exp[1] = 32'h0953_D051;
        bp_d[2] = 32'h8090_A0B0; bp_inv[2] = 1'b0; bp_exp[2] = 32'hCD60_E0E7;
        bp_d[3] = 32'hC0D0_E0F0; bp_inv[3] = 1'b0; bp_exp[3] = 32'hBA70_E18C;
        bp_d[4] = 32'hFF53_0100; bp_inv[4] = 1'b1; bp_exp[4] = 32'h7D50_0952;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        // Basic lookups
        single_beat("fwd", 32'hFF53_0100, 1'b0, 4'b0000, 4'h3, 32'h16ED_7C63);
        single_beat("inv", 32'h16ED_6352, 1'b1, 4'b0000, 4'hA, 32'hFF53_0048);
        single_beat("byp", 32'h0000_0000, 1'b0, 4'b0101, 4'h5, 32'h6300_6300);
        check("cnt_after3", beat_cnt, 3);

        // Clear alone
        @(posedge clk); #1; clr_cnt = 1'b1;
        @(posedge clk); #1; clr_cnt = 1'b0;
        check("cnt_clr", beat_cnt, 0);

        // Backpressure: out_ready low, pipeline fills to two beats
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = bp_d[0]; in_inv = bp_inv[0]; in_bypass = '0; in_tag = 4'd0;
        @(negedge clk);
        check("bp_rdy0", in_ready, 1);
        @(posedge clk); #1;
        in_data = bp_d[1]; in_inv = bp_inv[1]; in_tag = 4'd1;
        @(negedge clk);
        check("bp_rdy1", in_ready, 1);
        @(posedge clk); #1;
        in_data = bp_d[2]; in_inv = bp_inv[2]; in_tag = 4'd2;
        @(negedge clk);
        check("bp_full", in_ready, 0);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", out_data, bp_exp[0]);
        @(posedge clk); #1;
        in_data = 32'hDEAD_BEEF; in_inv = 1'b1; in_tag = 4'hF; in_bypass = 4'hF;
        @(negedge clk);
        check("bp_still_full", in_ready, 0);
        check("bp_hold_data2", out_data, bp_exp[0]);
        check("bp_hold_tag2", out_tag, 0);
        @(posedge clk); #1;
        in_data = bp_d[2]; in_inv = bp_inv[2]; in_tag = 4'd2; in_bypass = '0;
        out_ready = 1'b1;
        fork
            begin
                for (int n = 2; n < 5; n++) begin
                    in_valid = 1'b1; in_data = bp_d[n]; in_inv = bp_inv[n]; in_tag = 4'(n);
                    acc = 1'b0;
                    for (int w = 0; w < 20 && !acc; w++) begin
                        @(negedge clk); r = in_ready;
                        @(posedge clk); #1;
                        if (r) acc = 1'b1;
                    end
                    if (!acc) check("bp_accept", 0, 1);
                end
                in_valid = 1'b0;
            end
            begin
                got = 0;
                for (int w = 0; w < 40 && got < 5; w++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        check("bp_data", out_data, bp_exp[got]);
                        check("bp_tag", out_tag, 4'(got));
                        if (out_ready) got++;
                    end
                end
                check("bp_count", got, 5);
            end
        join
        @(negedge clk);
        check("bp_no_dup", out_valid, 0);
        check("bp_beat_cnt", beat_cnt, 5);

        // Mode interleave, with clear coinciding with the first transfer
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = '0; in_bypass = '0; in_inv = 1'b0; in_tag = 4'h1; clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0; in_inv = 1'b1; in_tag = 4'h2;
        @(posedge clk); #1;
        in_inv = 1'b0; in_tag = 4'h3;
        @(negedge clk);
        check("mix0_valid", out_valid, 1);
        check("mix0_data", out_data, 32'h6363_6363);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("mix1_valid", out_valid, 1);
        check("mix1_data", out_data, 32'h5252_5252);
        @(negedge clk);
        check("mix2_valid", out_valid, 1);
        check("mix2_data", out_data, 32'h6363_6363);
        check("mix2_tag", out_tag, 4'h3);
        @(negedge clk);
        check("mix_end", out_valid, 0);
        check("cnt_clr_xfer", beat_cnt, 3);

        // Saturation of the 4-bit counter after 17 transfers
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = '0; in_inv = 1'b0;
        repeat (17) @(posedge clk);
        #1; in_valid = 1'b0;
        @(negedge clk);
        check("cnt_sat", beat_cnt, 4'hF);
        repeat (3) @(negedge clk);
        check("sat_drained", out_valid, 0);

        // Reset with two beats in flight
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 32'h0102_0304; in_tag = 4'h7;
        @(posedge clk); #1;
        in_data = 32'h0506_0708;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_pre_valid", out_valid, 1);
        #2; rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_cnt", beat_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        single_beat("post_rst", 32'h0000_0053, 1'b0, 4'b0000, 4'h9, 32'h6363_63ED);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
